e203_itcm_ifu_tgt: RTL and testbench
====================================

E203_ITCM_IFU_TGT -- requirements
Module: e203_itcm_ifu_tgt

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous, active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 icb_cmd_valid  in  1  IFU fetch command valid.
REQ-005 icb_cmd_ready  out  1  command accepted when valid&ready.
REQ-006 icb_cmd_addr  in  16  ITCM byte address; bits [2:0] ignored.
REQ-007 icb_cmd_read  in  1  1=read; 0=write, which is illegal on this port.
REQ-008 icb_rsp_valid  out  1  response valid.
REQ-009 icb_rsp_ready  in  1  IFU accepts response.
REQ-010 icb_rsp_err  out  1  response error flag.
REQ-011 icb_rsp_rdata  out  64  fetched 64-bit line.
REQ-012 ifu_holdup  out  1  SRAM output still holds the last line this port read.
REQ-013 ram_cs  out  1  SRAM read strobe.
REQ-014 ram_addr  out  13  SRAM word address, icb_cmd_addr[15:3].
REQ-015 ram_dout  in  64  SRAM data, valid the cycle after ram_cs; held until the next access.
REQ-016 ext_ram_access  in  1  another master owns the SRAM this cycle.

Function
- REQ-017 SHALL keep an occupancy count cnt (0..2) = commands accepted and not yet answered.
- REQ-018 SHALL drive icb_cmd_ready = (cnt<2) & ~ext_ram_access.
- REQ-019 On an accepted read, SHALL assert ram_cs in the same cycle with ram_addr = addr[15:3], except in the skip case of REQ-027.
- REQ-020 On an accepted write, SHALL keep ram_cs=0.
  - Its response SHALL carry err=1, rdata=0.
  - The write SHALL clear the holdup state.
- REQ-021 Latency: a response SHALL be valid the first cycle after acceptance.
  - When the response buffer is empty, rdata SHALL bypass directly from ram_dout.
- REQ-022 An unaccepted response (valid & ~ready) SHALL be captured into a 2-entry in-order buffer.
  - It SHALL be presented unchanged until accepted.
- REQ-023 Responses SHALL return strictly in command order.
- REQ-024 cnt SHALL handle all simultaneous events in the same cycle:
  - accept and response handshake together: cnt unchanged.
  - accept only: cnt+1.
  - response handshake only: cnt-1.
- REQ-025 icb_rsp_err and icb_rsp_rdata SHALL be 0 whenever icb_rsp_valid=0.
- REQ-026 Holdup state:
  - holdup_vld SHALL set on any cycle with ram_cs=1; last_addr records ram_addr.
  - holdup_vld SHALL clear on ext_ram_access=1 or an accepted write.
  - ifu_holdup = holdup_vld.
- REQ-027 Skip case: an accepted read with holdup_vld=1 and addr[15:3]==last_addr SHALL keep ram_cs=0 and return the held ram_dout.
- REQ-028 ext_ram_access asserted while cnt>0 SHALL NOT corrupt in-flight data: the bypass value SHALL be captured into the buffer the cycle it is produced.

Reset
- REQ-029 During and after reset the outputs SHALL be: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, ram_cs=0, ifu_holdup=0.
- REQ-030 icb_cmd_ready SHALL be 1 after reset unless ext_ram_access=1.
- REQ-031 Reset SHALL clear cnt, the buffer, holdup_vld and last_addr (=0).
- REQ-032 Reset mid-operation SHALL discard in-flight commands and buffered responses; no response is ever issued for them.

Configuration
- REQ-033 Macro E203_ITCM_HOLDUP_EN:
  - Defined: REQ-026/027 are active.
  - Undefined: ifu_holdup is tied 0, every accepted read asserts ram_cs, and no holdup registers are built.

Structure
- REQ-034 Shared package e203_itcm_pkg SHALL hold ITCM_ADDR_W=16, ITCM_DATA_W=64, ITCM_RAM_AW=13, ITCM_RSP_DEPTH=2, and the response entry typedef (err, rdata).
- REQ-035 The response buffer SHALL be a sub-module e203_itcm_rsp_fifo: 2-entry, in-order, with full/empty outputs.

Verification
- REQ-036 Back-to-back read 0x0000 then 0x0008, rsp_ready=1 -> ram_cs both cycles, ram_addr 0 then 1, rsp 1 and 2 cycles later with matching ram_dout, err=0.
- REQ-037 Three reads with rsp_ready=0 -> cmd_ready drops after 2 accepts; rsp data held stable; raising ready drains in order; cmd_ready returns the cycle after cnt<2.
- REQ-038 Read 0x0010, then read 0x0014 with holdup_vld=1 -> second read has ram_cs=0 and ifu_holdup=1, returns the same line; with the macro undefined -> ram_cs=1 and ifu_holdup=0.
- REQ-039 Read 0x0010, ext_ram_access pulse, read 0x0010 -> ifu_holdup=0 after the pulse and second read asserts ram_cs.
- REQ-040 Write to 0x0020 -> ram_cs=0, rsp err=1, rdata=0, ifu_holdup cleared.
- REQ-041 rst=1 with 2 outstanding -> next cycle rsp_valid=0, cmd_ready=1, no stale response ever appears.

Source files
------------

// File: rtl/e203_itcm_pkg.sv
// rtl/e203_itcm_pkg.sv - shared ITCM widths, depths and response entry type
package e203_itcm_pkg;

  localparam int ITCM_ADDR_W    = 16;
  localparam int ITCM_DATA_W    = 64;
  localparam int ITCM_RAM_AW    = 13;
  localparam int ITCM_RSP_DEPTH = 2;

  typedef struct packed {
    logic                   err;
    logic [ITCM_DATA_W-1:0] rdata;
  } itcm_rsp_t;

endpackage

// File: rtl/e203_itcm_rsp_fifo.sv
// rtl/e203_itcm_rsp_fifo.sv - 2-entry in-order buffer for unaccepted ITCM responses
module e203_itcm_rsp_fifo
  import e203_itcm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [ITCM_DATA_W:0] push_data_i,
  input  logic                 pop_i,
  output logic [ITCM_DATA_W:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  itcm_rsp_t  mem_q [ITCM_RSP_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push_ok;
  logic       pop_ok;

  assign full_o  = (count_q == 2'(ITCM_RSP_DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < ITCM_RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/e203_itcm_ifu_tgt.sv
// rtl/e203_itcm_ifu_tgt.sv - IFU fetch target port onto the ITCM SRAM
// Optional line-holdup reuse is built when E203_ITCM_HOLDUP_EN is defined.
module e203_itcm_ifu_tgt
  import e203_itcm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic [ITCM_ADDR_W-1:0] icb_cmd_addr,
  input  logic                   icb_cmd_read,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic                   icb_rsp_err,
  output logic [ITCM_DATA_W-1:0] icb_rsp_rdata,
  output logic                   ifu_holdup,
  output logic                   ram_cs,
  output logic [ITCM_RAM_AW-1:0] ram_addr,
  input  logic [ITCM_DATA_W-1:0] ram_dout,
  input  logic                   ext_ram_access
);

  logic [1:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       pend_wr_q, pend_wr_d;
  logic       cmd_hs, rd_hs, wr_hs, rsp_hs, skip;
  itcm_rsp_t  pend_rsp, fifo_head, rsp_src;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       unused_bits;

  assign icb_cmd_ready = (cnt_q < 2'(ITCM_RSP_DEPTH)) & ~ext_ram_access;
  assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;
  assign rd_hs         = cmd_hs & icb_cmd_read;
  assign wr_hs         = cmd_hs & ~icb_cmd_read;
  assign ram_addr      = icb_cmd_addr[ITCM_ADDR_W-1:3];
  assign ram_cs        = rd_hs & ~skip & ~rst;

`ifdef E203_ITCM_HOLDUP_EN
  logic                   holdup_vld_q, holdup_vld_d;
  logic [ITCM_RAM_AW-1:0] last_addr_q, last_addr_d;

  assign skip       = holdup_vld_q & (ram_addr == last_addr_q);
  assign ifu_holdup = holdup_vld_q & ~rst;

  always_comb begin
    holdup_vld_d = holdup_vld_q;
    last_addr_d  = last_addr_q;
    if (ram_cs) begin
      holdup_vld_d = 1'b1;
      last_addr_d  = ram_addr;
    end else if (ext_ram_access | wr_hs) begin
      holdup_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdup_vld_q <= 1'b0;
      last_addr_q  <= '0;
    end else begin
      holdup_vld_q <= holdup_vld_d;
      last_addr_q  <= last_addr_d;
    end
  end
`else
  assign skip       = 1'b0;
  assign ifu_holdup = 1'b0;
`endif

  // The response produced this cycle comes straight off the SRAM (or is a write error);
  // it must be parked in the buffer now if it is not taken, since ram_dout may change.
  always_comb begin
    pend_rsp       = '0;
    pend_rsp.err   = pend_wr_q;
    pend_rsp.rdata = pend_wr_q ? '0 : ram_dout;
  end

  assign rsp_src       = fifo_empty ? pend_rsp : fifo_head;
  assign icb_rsp_valid = (~fifo_empty | pend_q) & ~rst;
  assign icb_rsp_err   = icb_rsp_valid & rsp_src.err;
  assign icb_rsp_rdata = icb_rsp_valid ? rsp_src.rdata : '0;
  assign rsp_hs        = icb_rsp_valid & icb_rsp_ready;

  assign fifo_pop  = ~fifo_empty & icb_rsp_ready;
  assign fifo_push = pend_q & ~(fifo_empty & icb_rsp_ready);

  e203_itcm_rsp_fifo u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (pend_rsp),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    cnt_d     = cnt_q + {1'b0, cmd_hs} - {1'b0, rsp_hs};
    pend_d    = cmd_hs;
    pend_wr_d = wr_hs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 2'd0;
      pend_q    <= 1'b0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign unused_bits = ^{icb_cmd_addr[2:0], fifo_full};

endmodule

// File: tb/tb_e203_itcm_ifu_tgt.sv
// tb/tb_e203_itcm_ifu_tgt.sv - self-checking bench for e203_itcm_ifu_tgt
module tb_e203_itcm_ifu_tgt;

`ifdef E203_ITCM_HOLDUP_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [15:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [63:0] icb_rsp_rdata;
  logic        ifu_holdup;
  logic        ram_cs;
  logic [12:0] ram_addr;
  logic [63:0] ram_dout = '0;
  logic        ext_ram_access;

  int vectors = 0;
  int errs    = 0;

  logic [63:0] mem [0:8191];
  logic [64:0] exp_q [$];
  bit          held_vld;
  logic [12:0] held_line;

  e203_itcm_ifu_tgt dut (
    .clk            (clk),
    .rst            (rst),
    .icb_cmd_valid  (icb_cmd_valid),
    .icb_cmd_ready  (icb_cmd_ready),
    .icb_cmd_addr   (icb_cmd_addr),
    .icb_cmd_read   (icb_cmd_read),
    .icb_rsp_valid  (icb_rsp_valid),
    .icb_rsp_ready  (icb_rsp_ready),
    .icb_rsp_err    (icb_rsp_err),
    .icb_rsp_rdata  (icb_rsp_rdata),
    .ifu_holdup     (ifu_holdup),
    .ram_cs         (ram_cs),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ext_ram_access (ext_ram_access)
  );

  always #5 clk = ~clk;

  // SRAM: data appears the cycle after a strobe; another master's access scrambles it.
  always @(posedge clk) begin
    if (ram_cs) ram_dout <= mem[ram_addr];
    else if (ext_ram_access) ram_dout <= {$urandom(), $urandom()};
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    icb_cmd_valid = 1'b0; icb_cmd_addr = '0; icb_cmd_read = 1'b1;
    icb_rsp_ready = 1'b0; ext_ram_access = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_rsp_payload", {icb_rsp_err, icb_rsp_rdata}, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_holdup", ifu_holdup, 0);
    exp_q.delete();
    held_vld = 0;
    held_line = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic [15:0] a, input logic rd,
                      input logic rr, input logic ex);
    logic acc, skp, exp_cs;
    icb_cmd_valid = v; icb_cmd_addr = a; icb_cmd_read = rd;
    icb_rsp_ready = rr; ext_ram_access = ex;
    @(negedge clk);
    acc = v && (exp_q.size() < 2) && !ex;
    chk("cmd_ready", icb_cmd_ready, (exp_q.size() < 2) && !ex);
    if (exp_q.size() > 0) begin
      chk("rsp_valid", icb_rsp_valid, 1);
      chk("rsp_payload", {icb_rsp_err, icb_rsp_rdata}, exp_q[0]);
      if (rr) void'(exp_q.pop_front());
    end else begin
      chk("rsp_valid", icb_rsp_valid, 0);
      chk("rsp_idle_payload", {icb_rsp_err, icb_rsp_rdata}, 0);
    end
    skp = HOLD && acc && rd && held_vld && (a[15:3] == held_line);
    exp_cs = acc && rd && !skp;
    chk("ram_cs", ram_cs, exp_cs);
    if (exp_cs) chk("ram_addr", ram_addr, a[15:3]);
    chk("ifu_holdup", ifu_holdup, HOLD && held_vld);
    if (acc) exp_q.push_back(rd ? {1'b0, mem[a[15:3]]} : {1'b1, 64'd0});
    if (ex) held_vld = 0;
    else if (exp_cs) begin held_vld = 1; held_line = a[15:3]; end
    else if (acc && !rd) held_vld = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] ra;
    for (int i = 0; i < 8192; i++) mem[i] = {$urandom(), $urandom()};
    do_reset();
    do_reset();
    // back-to-back reads, always ready
    step(1, 16'h0000, 1, 1, 0);
    step(1, 16'h0008, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // three reads against a stalled response channel, then drain
    step(1, 16'h0040, 1, 0, 0);
    step(1, 16'h0048, 1, 0, 0);
    step(1, 16'h0050, 1, 0, 0);
    step(1, 16'h0050, 1, 0, 0);
    step(1, 16'h0050, 1, 1, 0);
    step(1, 16'h0050, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // same line twice: reused when holdup is built
    step(1, 16'h0010, 1, 1, 0);
    step(1, 16'h0014, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // other master in between forces a real re-read
    step(1, 16'h0010, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 1);
    step(1, 16'h0010, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // illegal write answers with error and drops holdup
    step(1, 16'h0020, 1, 1, 0);
    step(1, 16'h0020, 0, 1, 0);
    step(1, 16'h0020, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // in-flight data must survive another master arriving while stalled
    step(1, 16'h0030, 1, 0, 0);
    step(0, 16'h0000, 1, 0, 1);
    step(0, 16'h0000, 1, 0, 0);
    step(0, 16'h0000, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // reset with two outstanding discards both
    step(1, 16'h0060, 1, 0, 0);
    step(1, 16'h0068, 1, 0, 0);
    do_reset();
    step(0, 16'h0000, 1, 1, 0);
    step(0, 16'h0000, 1, 1, 0);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra = 16'($urandom_range(0, 5) * 8 + $urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, ra, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
    end
    for (int n = 0; n < 4; n++) step(0, 16'h0000, 1, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
